larpix_uart_rx: RTL and testbench

LARPIX_UART_RX -- requirements
Module: larpix_uart_rx

---
 rtl/larpix_rx_pkg.sv | 19 +
 rtl/larpix_rx_fifo.sv | 64 ++++++
 rtl/larpix_uart_rx.sv | 162 ++++++++++++++++
 tb/tb_larpix_uart_rx.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/larpix_rx_pkg.sv
// Shared types and constants for the LArPix UART receive path.
package larpix_rx_pkg;

    localparam int unsigned WIDTH_DEFAULT = 64;

    // Receiver FSM encoding
    typedef logic [1:0] rx_state_t;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Buffered packet: payload plus parity flag (flag present only with parity checking)
    typedef struct packed {
        logic                     parity;
        logic [WIDTH_DEFAULT-1:0] payload;
    } packet_t;

endpackage

// File: rtl/larpix_rx_fifo.sv
// Synchronous packet FIFO with registered head, valid (non-empty) and full flags.
// DEPTH must be a power of two, at least 2.
module larpix_rx_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic              full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_n;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_n;
    logic              do_push;
    logic              do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        do_pop   = pop & valid;
        do_push  = push & (~full | do_pop);
        rd_ptr_n = rd_ptr + AW'(do_pop);
        count_n  = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head forwards the incoming entry when it lands in the slot about to become head
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            valid  <= (count_n != '0);
            full   <= (count_n == CW'(DEPTH));
            if (count_n != '0) begin
                head <= (do_push && (rd_ptr_n == wr_ptr)) ? push_data : mem[rd_ptr_n];
            end
        end
    end

endmodule

// File: rtl/larpix_uart_rx.sv
// UART receiver for one LArPix MISO lane: start/data/stop framing into a packet FIFO.
// Optional odd-parity flag per packet enabled by defining PARITY_CHECK_EN.
module larpix_uart_rx
    import larpix_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned WIDTH        = WIDTH_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             miso,
    input  logic             clr_errors,
    input  logic             packet_ready,
    output logic [WIDTH-1:0] packet_out,
    output logic             packet_valid,
    output logic             parity_err,
    output logic             framing_err,
    output logic             overflow
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned TW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW   = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
    localparam int unsigned ENTRY_W = WIDTH + 1;
`else
    localparam int unsigned ENTRY_W = WIDTH;
`endif

    logic [1:0]         sync_q;
    logic               rx;
    logic               rx_prev_q;
    rx_state_t          state_q;
    rx_state_t          state_n;
    logic [TW-1:0]      timer_q;
    logic [TW-1:0]      timer_n;
    logic [BW-1:0]      bit_cnt_q;
    logic [BW-1:0]      bit_cnt_n;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   shift_n;
    logic               push_c;
    logic               frame_bad_c;
    logic               pop_c;
    logic               fifo_full;
    logic [ENTRY_W-1:0] entry_c;
    logic [ENTRY_W-1:0] fifo_head;

    assign rx = sync_q[1];

    // Two-flop synchronizer, idle-high preset; previous sample arms start detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], miso};
            rx_prev_q <= rx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            framing_err <= 1'b0;
        end else begin
            state_q     <= state_n;
            timer_q     <= timer_n;
            bit_cnt_q   <= bit_cnt_n;
            shift_q     <= shift_n;
            framing_err <= frame_bad_c;
        end
    end

    // Bit-timer driven framing; start sampled mid-bit, later bits one bit period apart
    always_comb begin
        state_n     = state_q;
        timer_n     = timer_q + TW'(1);
        bit_cnt_n   = bit_cnt_q;
        shift_n     = shift_q;
        push_c      = 1'b0;
        frame_bad_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_n = '0;
                if (rx_prev_q && !rx) begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (timer_q == TW'(HALF - 1)) begin
                    timer_n   = '0;
                    bit_cnt_n = '0;
                    state_n   = rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
                    timer_n   = '0;
                    shift_n   = {rx, shift_q[WIDTH-1:1]};
                    bit_cnt_n = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(WIDTH - 1)) begin
                        state_n = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
                    timer_n     = '0;
                    state_n     = ST_IDLE;
                    push_c      = rx;
                    frame_bad_c = ~rx;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

`ifdef PARITY_CHECK_EN
    // Odd parity over the full word: flag set when the XOR of all bits is 0
    assign entry_c    = {~^shift_q, shift_q};
    assign packet_out = fifo_head[WIDTH-1:0];
    assign parity_err = fifo_head[WIDTH];
`else
    assign entry_c    = shift_q;
    assign packet_out = fifo_head;
    assign parity_err = 1'b0;
`endif

    assign pop_c = packet_valid & packet_ready;

    larpix_rx_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_c),
        .push_data (entry_c),
        .pop       (pop_c),
        .head      (fifo_head),
        .valid     (packet_valid),
        .full      (fifo_full)
    );

    // Sticky drop flag; a new drop outranks a clear in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (push_c && fifo_full && !pop_c) begin
            overflow <= 1'b1;
        end else if (clr_errors) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_larpix_uart_rx.sv
// Self-checking bench for larpix_uart_rx: framing, parity, glitch, overflow, reset, streaming.
module tb_larpix_uart_rx;

    localparam int unsigned CPB = 4;
    localparam int unsigned W   = 64;
    localparam int unsigned D   = 4;
`ifdef PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         miso = 1'b1;
    logic         clr_errors = 1'b0;
    logic         packet_ready = 1'b0;
    logic [W-1:0] packet_out;
    logic         packet_valid;
    logic         parity_err;
    logic         framing_err;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rise_cyc = -1;
    int fe_cnt   = 0;
    logic valid_d = 1'b0;
    bit   b2b_log = 1'b0;
    logic [W:0] b2b_q[$];

    always #5 clk = ~clk;

    larpix_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .WIDTH        (W),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .miso         (miso),
        .clr_errors   (clr_errors),
        .packet_ready (packet_ready),
        .packet_out   (packet_out),
        .packet_valid (packet_valid),
        .parity_err   (parity_err),
        .framing_err  (framing_err),
        .overflow     (overflow)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (packet_valid && !valid_d) rise_cyc = cyc;
        valid_d = packet_valid;
        if (framing_err) fe_cnt++;
        if (b2b_log && packet_valid && packet_ready) b2b_q.push_back({parity_err, packet_out});
    end

    function automatic logic exp_parity(input logic [W-1:0] d);
        return PAR_EN & ~(^d);
    endfunction

    function automatic logic [W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic drive_bit(input logic b);
        miso = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Start bit, W data bits LSB first, stop bit, then idle gap; t0 = cycle the start bit began
    task automatic send_frame(input logic [W-1:0] d, input logic stop, output int t0);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < int'(W); i++) drive_bit(d[i]);
        drive_bit(stop);
        miso = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic pop_expect(input logic [W:0] exp, input string name);
        int k;
        k = 0;
        while (!packet_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (packet_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s valid: got %b want 1 (timeout)", name, packet_valid);
        end else begin
            n_checks++;
            if (packet_out !== exp[W-1:0]) begin
                n_fail++;
                $display("FAIL %s data: got %h want %h", name, packet_out, exp[W-1:0]);
            end
            n_checks++;
            if (parity_err !== exp[W]) begin
                n_fail++;
                $display("FAIL %s parity: got %b want %b", name, parity_err, exp[W]);
            end
            packet_ready = 1'b1;
            @(negedge clk);
            packet_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({packet_valid, packet_out, parity_err, framing_err, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h p=%b f=%b o=%b want all 0",
                     packet_valid, packet_out, parity_err, framing_err, overflow);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (packet_valid !== 1'b0 || framing_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got v=%b f=%b want 0 0", packet_valid, framing_err);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] d;
        int t0;
        int lat;
        d = 64'hA5A5_0000_1234_5679;
        rise_cyc = -1;
        send_frame(d, 1'b1, t0);
        lat = rise_cyc - t0;
        // Stop bit starts (W+1)*CPB cycles in; mid-bit sample, 2-flop sync and 1-cycle push fall in this window
        n_checks++;
        if (lat < int'((W + 1) * CPB) + 2 || lat > int'((W + 1) * CPB) + 6) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want %0d..%0d", lat,
                     (W + 1) * CPB + 2, (W + 1) * CPB + 6);
        end
        pop_expect({exp_parity(d), d}, "basic");
        n_checks++;
        if (packet_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_empty_after_pop: got %b want 0", packet_valid);
        end
    endtask

    task automatic test_parity();
        logic [W-1:0] d;
        int t0;
        d = 64'hA5A5_0000_1234_5678;
        send_frame(d, 1'b1, t0);
        pop_expect({exp_parity(d), d}, "parity_flip");
        for (int i = 0; i < 4; i++) begin
            d = rand64();
            send_frame(d, 1'b1, t0);
            pop_expect({exp_parity(d), d}, "parity_rand");
        end
    endtask

    task automatic test_glitch();
        int fe0;
        int t0;
        logic [W-1:0] d;
        fe0 = fe_cnt;
        miso = 1'b0;
        @(negedge clk);
        miso = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (packet_valid !== 1'b0 || fe_cnt != fe0) begin
            n_fail++;
            $display("FAIL glitch: got v=%b fe=%0d want v=0 fe=0", packet_valid, fe_cnt - fe0);
        end
        d = rand64();
        send_frame(d, 1'b1, t0);
        pop_expect({exp_parity(d), d}, "after_glitch");
    endtask

    task automatic test_framing();
        int fe0;
        int t0;
        logic [W-1:0] d;
        fe0 = fe_cnt;
        send_frame(rand64(), 1'b0, t0);
        n_checks++;
        if (fe_cnt - fe0 != 1) begin
            n_fail++;
            $display("FAIL framing_pulse_cycles: got %0d want 1", fe_cnt - fe0);
        end
        n_checks++;
        if (packet_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL framing_no_push: got %b want 0", packet_valid);
        end
        d = rand64();
        send_frame(d, 1'b1, t0);
        pop_expect({exp_parity(d), d}, "after_framing");
    endtask

    task automatic test_overflow();
        logic [W:0]   q[$];
        logic [W-1:0] d;
        logic         ovf_exp;
        int t0;
        ovf_exp = 1'b0;
        packet_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = rand64();
            send_frame(d, 1'b1, t0);
            if (q.size() < int'(D)) q.push_back({exp_parity(d), d});
            else ovf_exp = 1'b1;
        end
        n_checks++;
        if (overflow !== ovf_exp) begin
            n_fail++;
            $display("FAIL overflow_set: got %b want %b", overflow, ovf_exp);
        end
        while (q.size() > 0) pop_expect(q.pop_front(), "overflow_order");
        n_checks++;
        if (packet_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_drained: got %b want 0", packet_valid);
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b want 1", overflow);
        end
        clr_errors = 1'b1;
        @(negedge clk);
        clr_errors = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        int t0;
        d = rand64();
        drive_bit(1'b0);
        for (int i = 0; i < 30; i++) drive_bit(d[i]);
        miso = d[30];
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        miso = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (int'((W + 4) * CPB)) @(negedge clk);
        n_checks++;
        if (packet_valid !== 1'b0 || framing_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abandon: got v=%b f=%b want 0 0", packet_valid, framing_err);
        end
        d = rand64();
        send_frame(d, 1'b1, t0);
        pop_expect({exp_parity(d), d}, "after_reset_mid");
    endtask

    task automatic test_back_to_back();
        logic [W:0]   exp_q[$];
        logic [W-1:0] d;
        int t0;
        b2b_q.delete();
        packet_ready = 1'b1;
        b2b_log = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = rand64();
            exp_q.push_back({exp_parity(d), d});
            send_frame(d, 1'b1, t0);
        end
        b2b_log = 1'b0;
        packet_ready = 1'b0;
        n_checks++;
        if (b2b_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want %0d", b2b_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (b2b_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_entry%0d: got %h want %h", i, b2b_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_framing();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
